// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-stage bubble constants for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [3:0] OPCODE_NOP = 4'b1111;

  // Opcode sits in the low nibble of every control field, so one bubble pattern serves all stages.
  localparam int IF_ID_CTRL_W  = 24;
  localparam int ID_RR_CTRL_W  = 24;
  localparam int RR_EX_CTRL_W  = 24;
  localparam int EX_MEM_CTRL_W = 24;
  localparam int MEM_WB_CTRL_W = 24;

  localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_CTRL_NOP  = {{(IF_ID_CTRL_W-4){1'b0}}, OPCODE_NOP};
  localparam logic [ID_RR_CTRL_W-1:0]  ID_RR_CTRL_NOP  = {{(ID_RR_CTRL_W-4){1'b0}}, OPCODE_NOP};
  localparam logic [RR_EX_CTRL_W-1:0]  RR_EX_CTRL_NOP  = {{(RR_EX_CTRL_W-4){1'b0}}, OPCODE_NOP};
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_NOP = {{(EX_MEM_CTRL_W-4){1'b0}}, OPCODE_NOP};
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_CTRL_NOP = {{(MEM_WB_CTRL_W-4){1'b0}}, OPCODE_NOP};

endpackage

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with kill-to-NOP, flush and optional skid entry
// Define PIPE_SKID_EN to build the second (skid) register and a fully registered in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {{(CTRL_W-4){1'b0}}, OPCODE_NOP}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              in_xfer, out_xfer;
  logic [CTRL_W-1:0] in_ctrl_eff;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  assign in_ready = (state_q != ST_TWO);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_valid   = (state_q != ST_EMPTY);
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid && out_ready;
  assign in_ctrl_eff = in_kill ? CTRL_NOP : in_ctrl;

  // Idle output always reads as a bubble for consumers that ignore out_valid.
  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q : CTRL_NOP;
  assign occupancy = (state_q == ST_TWO) ? 2'd2 :
                     (state_q == ST_ONE) ? 2'd1 : 2'd0;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
`ifdef PIPE_SKID_EN
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
`endif
    if (flush) begin
      state_d  = ST_EMPTY;
      m_ctrl_d = CTRL_NOP;
`ifdef PIPE_SKID_EN
      s_ctrl_d = CTRL_NOP;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl_eff;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl_eff;
          end
`ifdef PIPE_SKID_EN
          else if (in_xfer) begin
            s_data_d = in_data;
            s_ctrl_d = in_ctrl_eff;
            state_d  = ST_TWO;
          end
`endif
          else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_TWO: begin
          if (out_xfer) begin
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            state_d  = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_NOP;
`ifdef PIPE_SKID_EN
      s_data_q <= '0;
      s_ctrl_q <= CTRL_NOP;
`endif
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
`ifdef PIPE_SKID_EN
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid (skid or plain build via PIPE_SKID_EN)
module tb_pipe_stage_skid;

  localparam int              DW  = 128;
  localparam int              CW  = 24;
  localparam logic [CW-1:0]   NOP = 24'h00000F;
`ifdef PIPE_SKID_EN
  localparam int              CAP = 2;
`else
  localparam int              CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_kill;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int checks   = 0;
  int failures = 0;
  logic [DW+CW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_kill   (in_kill),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare against the scoreboard, update it from the driven inputs, then advance one cycle.
  task automatic step();
    logic             exp_ready;
    logic [DW+CW-1:0] head;
    #1;
    if (CAP == 2) exp_ready = (sb.size() < 2);
    else          exp_ready = (sb.size() == 0) || out_ready;
    check("occupancy", DW'(occupancy), DW'(sb.size()));
    check("out_valid", DW'(out_valid), DW'(sb.size() != 0));
    check("in_ready",  DW'(in_ready),  DW'(exp_ready));
    if (sb.size() != 0) begin
      head = sb[0];
      check("out_data", out_data, head[DW+CW-1:CW]);
      check("out_ctrl", DW'(out_ctrl), DW'(head[CW-1:0]));
    end else begin
      check("idle_ctrl", DW'(out_ctrl), DW'(NOP));
    end
    if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (in_valid && exp_ready) sb.push_back({in_data, in_kill ? NOP : in_ctrl});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic k);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_kill  = k;
  endtask

  initial begin
    rst = 1'b1;
    offer(1'b0, '0, '0, 1'b0);
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data",  out_data, '0);
    check("rst_out_ctrl",  DW'(out_ctrl), DW'(NOP));
    check("rst_occupancy", DW'(occupancy), '0);
    check("rst_in_ready",  DW'(in_ready), DW'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, DW'(i), 24'h000100 + CW'(i), 1'b0);
      step();
    end
    offer(1'b0, '0, '0, 1'b0);
    step();
    step();

    // Backpressure
    out_ready = 1'b0;
    offer(1'b1, DW'(128'hA), 24'h0000A0, 1'b0);
    step();
`ifdef PIPE_SKID_EN
    offer(1'b1, DW'(128'hB), 24'h0000B0, 1'b0);
    step();
    offer(1'b1, DW'(128'hC), 24'h0000C0, 1'b0);
    step();
    offer(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    step();
`else
    offer(1'b1, DW'(128'hB), 24'h0000B0, 1'b0);
    #1;
    check("comb_ready_low", DW'(in_ready), '0);
    out_ready = 1'b1;
    #1;
    check("comb_ready_high", DW'(in_ready), DW'(1'b1));
    step();
    offer(1'b0, '0, '0, 1'b0);
    step();
    step();
`endif

    // Kill turns the control field into a bubble but keeps data
    out_ready = 1'b1;
    offer(1'b1, DW'(128'hABC), 24'hFFFFFF, 1'b1);
    step();
    offer(1'b0, DW'(128'h123), 24'hFFFFFF, 1'b1);
    step();
    in_kill = 1'b0;
    step();

    // Flush from full with a beat offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      offer(1'b1, DW'(128'h50 + i), 24'h000500 + CW'(i), 1'b0);
      step();
    end
    offer(1'b1, DW'(128'hDEAD), 24'h00DEA0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, '0, '0, 1'b0);
    step();
    out_ready = 1'b1;
    step();

    // Flush while an output transfer completes
    offer(1'b1, DW'(128'h77), 24'h000770, 1'b0);
    step();
    offer(1'b0, '0, '0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      offer(1'b1, DW'(128'h90 + i), 24'h000900 + CW'(i), 1'b0);
      step();
    end
    offer(1'b0, '0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", DW'(out_valid), '0);
    check("arst_out_data",  out_data, '0);
    check("arst_out_ctrl",  DW'(out_ctrl), DW'(NOP));
    check("arst_occupancy", DW'(occupancy), '0);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    out_ready = 1'b1;
    offer(1'b1, DW'(128'h3C), 24'h0003C0, 1'b0);
    step();
    offer(1'b0, '0, '0, 1'b0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
